// File: rtl/fir_host_pkg.sv
// fir_host_pkg: command opcodes, sequencer states and memory-select codes shared by the FIR host sequencer.
package fir_host_pkg;
    typedef enum logic [1:0] {
        LOAD_WSP    = 2'd0,
        LOAD_PROBKI = 2'd1,
        RUN         = 2'd2,
        READ        = 2'd3
    } cmd_op_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        START_P  = 3'd2,
        WAIT     = 3'd3,
        RD_ISSUE = 3'd4,
        RD_CAP   = 3'd5,
        OUT      = 3'd6
    } state_t;

    localparam logic MEM_SEL_WSP    = 1'b0;
    localparam logic MEM_SEL_PROBKI = 1'b1;
endpackage

// File: rtl/fir_host_seq_if.sv
// fir_host_seq_if: host command/load streams, FIR memory and handshake signals, result stream.
interface fir_host_seq_if
    import fir_host_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OUT_W  = 32,
    parameter int ADDR_W = 6
);
    logic              cmd_valid, cmd_ready;
    cmd_op_t           cmd_op;
    logic [ADDR_W-1:0] cmd_len;
    logic              s_valid, s_ready;
    logic [DATA_W-1:0] s_data;
    logic              mem_wr_en, mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              START, pracuje, DONE;
    logic              res_rd_en;
    logic [ADDR_W-1:0] res_addr;
    logic [OUT_W-1:0]  res_rdata;
    logic              m_valid, m_ready, m_last;
    logic [OUT_W-1:0]  m_data;
    logic              busy, run_done, err;

    modport master (
        input  cmd_valid, cmd_op, cmd_len, s_valid, s_data, pracuje, DONE, res_rdata, m_ready,
        output cmd_ready, s_ready, mem_wr_en, mem_sel, mem_addr, mem_wdata, START,
               res_rd_en, res_addr, m_valid, m_data, m_last, busy, run_done, err
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_len, s_valid, s_data, pracuje, DONE, res_rdata, m_ready,
        input  cmd_ready, s_ready, mem_wr_en, mem_sel, mem_addr, mem_wdata, START,
               res_rd_en, res_addr, m_valid, m_data, m_last, busy, run_done, err
    );
endinterface

// File: rtl/fir_out_reg.sv
// fir_out_reg: result holding register; data and last stay frozen from capture until the beat is accepted.
module fir_out_reg #(
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             last_i,
    input  logic [OUT_W-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic             last_o,
    output logic [OUT_W-1:0] data_o,
    output logic             fire_o
);
    logic             valid_q, last_q;
    logic [OUT_W-1:0] data_q;

    assign valid_o = valid_q;
    assign last_o  = last_q;
    assign data_o  = data_q;
    assign fire_o  = valid_q && ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            last_q  <= last_i;
            data_q  <= data_i;
        end else if (fire_o) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end
    end
endmodule

// File: rtl/fir_host_seq.sv
// fir_host_seq: host-side sequencer for the FIR core (memory loads, START/DONE run handshake, result readback).
// Defining FIR_TIMEOUT_EN adds a WAIT-state watchdog of TIMEOUT_CYC cycles.
module fir_host_seq
    import fir_host_pkg::*;
#(
    parameter int N_WSP       = 16,
    parameter int N_PROBEK    = 64,
    parameter int DATA_W      = 16,
    parameter int OUT_W       = 32,
    parameter int ADDR_W      = $clog2(N_PROBEK),
    parameter int TIMEOUT_CYC = 4096
) (
    input logic            clk,
    input logic            rst,
    fir_host_seq_if.master bus
);
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d, len_q, len_d;
    logic              sel_q, sel_d, err_q, err_d, done_q, done_d;
    logic              wr, rd, bad, fire;
    logic [DATA_W-1:0] wdata;

    if (N_WSP > N_PROBEK || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("fir_host_seq: N_WSP must not exceed N_PROBEK and TIMEOUT_CYC must be at least 2");
    end

`ifdef FIR_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC);
    logic [WD_W-1:0] wd_q, wd_d;
`endif

    assign wr    = state_q == LOAD && bus.s_valid && !bus.pracuje;
    assign rd    = state_q == RD_ISSUE;
    assign wdata = wr ? bus.s_data : '0;
    // RUN carries no length, so only the transfer ops are range-checked
    assign bad   = bus.cmd_op != RUN && (int'(bus.cmd_len) >= N_PROBEK ||
                   (bus.cmd_op == LOAD_WSP && int'(bus.cmd_len) >= N_WSP));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sel_d   = sel_q;
        err_d   = 1'b0;
        done_d  = 1'b0;
`ifdef FIR_TIMEOUT_EN
        wd_d    = wd_q;
`endif
        case (state_q)
            IDLE: if (bus.cmd_valid && bad) err_d = 1'b1;
                  else if (bus.cmd_valid) begin
                      cnt_d   = '0;
                      len_d   = bus.cmd_len;
                      sel_d   = bus.cmd_op == LOAD_PROBKI ? MEM_SEL_PROBKI : MEM_SEL_WSP;
                      state_d = bus.cmd_op == RUN ? START_P : bus.cmd_op == READ ? RD_ISSUE : LOAD;
                  end
            LOAD: if (wr) begin
                      cnt_d   = cnt_q + 1'b1;
                      state_d = cnt_q == len_q ? IDLE : LOAD;
                  end
            START_P: begin
                state_d = WAIT;
`ifdef FIR_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            WAIT: if (bus.DONE) begin
                      state_d = IDLE;
                      done_d  = 1'b1;
                  end
`ifdef FIR_TIMEOUT_EN
                  else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                      state_d = IDLE;
                      err_d   = 1'b1;
                  end else wd_d = wd_q + 1'b1;
`endif
            RD_ISSUE: state_d = RD_CAP;
            RD_CAP:   state_d = OUT;
            OUT: if (fire) begin
                     state_d = cnt_q == len_q ? IDLE : RD_ISSUE;
                     cnt_d   = cnt_q == len_q ? cnt_q : cnt_q + 1'b1;
                 end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            sel_q   <= MEM_SEL_WSP;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

`ifdef FIR_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) wd_q <= '0;
        else wd_q <= wd_d;
    end
`endif

    fir_out_reg #(.OUT_W(OUT_W)) u_out (
        .clk     (clk),
        .rst     (rst),
        .load_i  (state_q == RD_CAP),
        .last_i  (cnt_q == len_q),
        .data_i  (bus.res_rdata),
        .ready_i (bus.m_ready),
        .valid_o (bus.m_valid),
        .last_o  (bus.m_last),
        .data_o  (bus.m_data),
        .fire_o  (fire)
    );

    assign bus.cmd_ready = state_q == IDLE;
    assign bus.s_ready   = state_q == LOAD && !bus.pracuje;
    assign bus.mem_wr_en = wr;
    assign bus.mem_sel   = sel_q;
    assign bus.mem_addr  = wr ? cnt_q : '0;
    assign bus.mem_wdata = wdata;
    assign bus.START     = state_q == START_P;
    assign bus.res_rd_en = rd;
    assign bus.res_addr  = rd ? cnt_q : '0;
    assign bus.busy      = state_q != IDLE;
    assign bus.run_done  = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_fir_host_seq.sv
// tb_fir_host_seq: randomized self-checking bench for fir_host_seq against a rule-level reference model.
// The FIR_TIMEOUT_EN watchdog section runs only when the macro is defined.
module tb_fir_host_seq;
    import fir_host_pkg::*;

    localparam int N_WSP = 16, N_PROBEK = 64, DATA_W = 16, OUT_W = 32, ADDR_W = 7, TIMEOUT_CYC = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0, n_err = 0;
    logic [OUT_W-1:0] res_mem [2**ADDR_W];

    fir_host_seq_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) bus ();

    fir_host_seq #(
        .N_WSP(N_WSP), .N_PROBEK(N_PROBEK), .DATA_W(DATA_W), .OUT_W(OUT_W),
        .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.res_rd_en) bus.res_rdata <= res_mem[bus.res_addr];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic bit illegal(cmd_op_t op, int len);
        return op != RUN && (len >= N_PROBEK || (op == LOAD_WSP && len >= N_WSP));
    endfunction

    task automatic issue(input cmd_op_t op, input int len);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_len   = ADDR_W'(len);
        tick;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, {bus.START, bus.mem_wr_en, bus.res_rd_en, bus.m_valid, bus.m_last, bus.busy,
                            bus.run_done, bus.err, bus.s_ready, bus.mem_addr, bus.res_addr, bus.mem_wdata}, '0);
        chk({tag, "_mdata"}, bus.m_data, '0);
        chk({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
    endtask

    task automatic do_err(input cmd_op_t op, input int len);
        issue(op, len);
        chk("err_pulse", {bus.err, bus.busy, bus.cmd_ready}, 3'b101);
        bus.s_valid = 1'b1;
        tick;
        chk("err_clear", {bus.err, bus.busy, bus.mem_wr_en, bus.s_ready}, 4'b0000);
        bus.s_valid = 1'b0;
    endtask

    task automatic do_load(input cmd_op_t op, input int len, input bit rnd);
        int k = 0, cyc = 0;
        bit sv, pr, hs;
        issue(op, len);
        while (k <= len && cyc < 400) begin
            sv = rnd ? $urandom_range(0, 3) != 0 : 1'b1;
            pr = rnd ? $urandom_range(0, 4) == 0 : 1'b0;
            bus.s_valid = sv;
            bus.pracuje = pr;
            bus.s_data  = rnd ? DATA_W'($urandom) : DATA_W'(k + 1);
            #1;
            hs = sv && !pr;
            chk("load_wr", bus.mem_wr_en, hs);
            chk("load_s_ready", bus.s_ready, !pr);
            if (hs) chk("load_port", {bus.mem_sel, bus.mem_addr, bus.mem_wdata},
                        {op == LOAD_PROBKI, ADDR_W'(k), bus.s_data});
            tick;
            if (hs) k++;
            cyc++;
        end
        bus.s_valid = 1'b0;
        bus.pracuje = 1'b0;
        chk("load_count", k, len + 1);
        chk("load_end", {bus.cmd_ready, bus.busy, bus.s_ready}, 3'b100);
    endtask

    task automatic do_run(input int delay);
        int c = 2;
        issue(RUN, 0);
        chk("start_hi", {bus.START, bus.busy}, 2'b11);
        tick;
        chk("start_lo", {bus.START, bus.busy}, 2'b01);
        bus.pracuje = 1'b1;
        while (c < delay) begin
            tick;
            c++;
            chk("wait_state", {bus.START, bus.busy, bus.run_done, bus.err}, 4'b0100);
        end
        bus.DONE = 1'b1;
        #1;
        chk("done_cycle", {bus.run_done, bus.busy}, 2'b01);
        tick;
        bus.DONE    = 1'b0;
        bus.pracuje = 1'b0;
        chk("run_done", {bus.run_done, bus.busy, bus.cmd_ready}, 3'b101);
        tick;
        chk("run_done_pulse", bus.run_done, 1'b0);
    endtask

    task automatic do_read(input int len, input int stall_beat, input int stall_n);
        int n, s;
        issue(READ, len);
        for (int k = 0; k <= len; k++) begin
            chk("rd_issue", {bus.res_rd_en, bus.res_addr}, {1'b1, ADDR_W'(k)});
            n = 0;
            while (!bus.m_valid && n < 10) begin
                tick;
                n++;
            end
            chk("rd_latency", n, 2);
            chk("rd_beat", {bus.m_last, bus.m_data}, {k == len, res_mem[k]});
            s = (k == stall_beat) ? stall_n : $urandom_range(0, 2);
            for (int i = 0; i < s; i++) begin
                tick;
                chk("rd_hold", {bus.m_valid, bus.m_last, bus.m_data}, {1'b1, k == len, res_mem[k]});
            end
            bus.m_ready = 1'b1;
            tick;
            bus.m_ready = 1'b0;
        end
        chk("rd_end", {bus.busy, bus.m_valid, bus.cmd_ready}, 3'b001);
    endtask

    initial begin
        cmd_op_t op;
        int len;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = LOAD_WSP;
        bus.cmd_len   = '0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.pracuje   = 1'b0;
        bus.DONE      = 1'b0;
        bus.m_ready   = 1'b0;
        for (int a = 0; a < 2**ADDR_W; a++) res_mem[a] = OUT_W'(32'h10 + a);
        repeat (3) tick;
        check_zero("reset");
        rst = 1'b0;
        tick;

        do_load(LOAD_WSP, 3, 1'b0);
        do_err(LOAD_PROBKI, N_PROBEK);
        do_err(LOAD_WSP, N_WSP);
        do_err(READ, N_PROBEK);
        do_load(LOAD_WSP, N_WSP - 1, 1'b1);
        do_load(LOAD_PROBKI, N_PROBEK - 1, 1'b1);
        do_load(LOAD_PROBKI, 0, 1'b1);
`ifdef FIR_TIMEOUT_EN
        do_run(9);
`else
        do_run(40);
`endif
        do_read(2, 1, 5);
        do_read(0, 0, 3);

        bus.DONE = 1'b1;
        tick;
        bus.DONE = 1'b0;
        tick;
        chk("idle_stray_done", {bus.run_done, bus.busy, bus.err}, 3'b000);

        issue(RUN, 0);
        tick;
        bus.pracuje = 1'b1;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        bus.pracuje = 1'b0;
        check_zero("rst_mid_wait");
        bus.DONE = 1'b1;
        tick;
        bus.DONE = 1'b0;
        chk("rst_stray_done", {bus.run_done, bus.busy, bus.err}, 3'b000);
        tick;
        chk("rst_stray_done2", {bus.run_done, bus.busy}, 2'b00);

`ifdef FIR_TIMEOUT_EN
        issue(RUN, 0);
        tick;
        bus.pracuje = 1'b1;
        for (int c = 3; c <= 9; c++) begin
            tick;
            chk("wd_wait", {bus.err, bus.busy}, 2'b01);
        end
        tick;
        chk("wd_fire", {bus.err, bus.busy, bus.run_done}, 3'b100);
        bus.pracuje = 1'b0;
        bus.DONE    = 1'b1;
        tick;
        bus.DONE    = 1'b0;
        chk("wd_err_pulse", bus.err, 1'b0);
        tick;
        chk("wd_stray_done", {bus.run_done, bus.busy}, 2'b00);
`endif

        for (int a = 0; a < 2**ADDR_W; a++) res_mem[a] = $urandom;
        for (int it = 0; it < 30; it++) begin
            op = cmd_op_t'($urandom_range(0, 3));
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(N_WSP, 2**ADDR_W - 1)
                : $urandom_range(0, op == READ ? 5 : op == LOAD_WSP ? N_WSP - 1 : N_PROBEK - 1);
            if (illegal(op, len)) do_err(op, len);
            else if (op == RUN) begin
`ifdef FIR_TIMEOUT_EN
                do_run($urandom_range(3, 9));
`else
                do_run($urandom_range(3, 60));
`endif
            end else if (op == READ) do_read(len, $urandom_range(0, len), $urandom_range(0, 4));
            else do_load(op, len, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/fir_host_seq.md
# fir_host_seq

Host-side sequencer for the FIR core: the initiator of the FIR controller's START/DONE/pracuje handshake. It accepts commands from a host stream to load coefficient and sample memories and to start a filter run. It waits for DONE, then reads the result memory and streams the results out with valid/ready. It sits between the host interface and the FIR memory/interface muxes, and drives memories only while the core reports pracuje = 0.

## Interface
Parameters:
- N_WSP, 16: coefficient memory depth.
- N_PROBEK, 64: sample and result memory depth.
- DATA_W, 16: sample and coefficient width.
- OUT_W, 32: result word width.
- ADDR_W, $clog2(N_PROBEK): address and length width. Must satisfy N_WSP ≤ N_PROBEK.
- TIMEOUT_CYC, 4096: run watchdog limit. Used only with FIR_TIMEOUT_EN.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_op  in  2  0 = LOAD_WSP, 1 = LOAD_PROBKI, 2 = RUN, 3 = READ.
- cmd_len  in  ADDR_W  word count minus 1, for LOAD and READ.
- s_valid / s_ready / s_data  in / out / in  1 / 1 / DATA_W  load data stream.
- mem_wr_en, mem_sel, mem_addr, mem_wdata  out  1, 1, ADDR_W, DATA_W  memory write port. mem_sel: 0 = coefficient, 1 = sample.
- START  out  1  one-cycle run request to the FIR controller.
- pracuje  in  1  FIR busy.
- DONE  in  1  FIR completion pulse.
- res_rd_en, res_addr  out  1, ADDR_W  result memory read. Read latency is 1 cycle.
- res_rdata  in  OUT_W  result read data.
- m_valid / m_ready / m_data / m_last  out / in / out / out  1 / 1 / OUT_W / 1  result stream.
- busy  out  1  high in every state except IDLE.
- run_done  out  1  one-cycle pulse at run completion.
- err  out  1  one-cycle error pulse.

## Operation
States: IDLE, LOAD, START_P, WAIT, RD_ISSUE, RD_CAP, OUT.
- IDLE:
  - cmd_ready = 1. A command is accepted on cmd_valid & cmd_ready.
  - LOAD_WSP with cmd_len ≥ N_WSP, or any LOAD/READ with cmd_len ≥ N_PROBEK: err pulses, the command is dropped, and the state stays IDLE.
  - Otherwise: LOAD ops → LOAD with cnt = 0 and mem_sel latched; RUN → START_P; READ → RD_ISSUE with cnt = 0.
- LOAD:
  - s_ready = !pracuje.
  - On each s_valid & s_ready: mem_wr_en = 1, mem_addr = cnt, mem_wdata = s_data, and cnt increments.
  - The transfer with cnt == len → IDLE.
- START_P: START = 1 for exactly one cycle → WAIT.
- WAIT:
  - On DONE → IDLE, and run_done pulses in the next cycle.
  - pracuje is ignored in this state.
- RD_ISSUE: res_rd_en = 1, res_addr = cnt → RD_CAP.
- RD_CAP: capture res_rdata into the output register → OUT.
- OUT:
  - m_valid = 1 and m_last = (cnt == len).
  - On m_ready: if last → IDLE, else cnt increments → RD_ISSUE.
  - m_data is held stable while m_valid & !m_ready.
- DONE outside WAIT is ignored. s_valid outside LOAD is not accepted (s_ready = 0).

## Timing
- Reset: state IDLE, cnt 0. Outputs START, mem_wr_en, res_rd_en, m_valid, m_last, busy, run_done, err, s_ready are all 0. Addresses and data are 0.
- Reset mid-run clears the sequencer only. The FIR core shares rst, so both return to idle together.
- The RUN command is accepted in cycle t. START is high in t+1, and the FIR asserts pracuje from t+2.
- DONE sampled in cycle d → state IDLE in d+1, run_done high in d+1, cmd_ready high in d+1.
- LOAD: one word per cycle when s_valid is held high and pracuje = 0. The write is issued in the same cycle as the handshake.
- READ: first m_valid 2 cycles after RD_ISSUE. Steady throughput is one word per 3 cycles with m_ready held high.
- cmd_len = 0 gives a single-word transfer, and m_last is set on the first beat.

## Configuration
FIR_TIMEOUT_EN:
- Defined: a watchdog counter clears on entering WAIT and increments each WAIT cycle. At TIMEOUT_CYC-1 cycles without DONE: err pulses, the state goes to IDLE, and run_done is not pulsed. A later stray DONE is ignored.
- Undefined: WAIT has no limit, and err comes only from length violations.

## Structure
- Package fir_host_pkg: cmd_op_t enum (LOAD_WSP, LOAD_PROBKI, RUN, READ), state_t enum, and the MEM_SEL_WSP/MEM_SEL_PROBKI constants.
- Sub-module fir_out_reg: the output holding register with the m_valid/m_ready handshake and m_last. The FSM and counters stay in fir_host_seq.

## Test plan
- LOAD_WSP, cmd_len = 3, s_data 1, 2, 3, 4 back-to-back → mem_wr_en on 4 consecutive cycles, addr 0..3, mem_sel = 0, then cmd_ready = 1.
- LOAD_PROBKI with cmd_len = N_PROBEK (64) → err pulses for 1 cycle, no writes, state IDLE.
- RUN accepted at t, DONE driven at t+40 → START high only at t+1, run_done at t+41, busy low from t+41.
- READ, cmd_len = 2, res_rdata = 0x10 + addr, m_ready low for 5 cycles on the second beat → m_data 0x10, 0x11, 0x12 in order. m_data is stable while stalled, and m_last is set only with 0x12.
- rst asserted during WAIT, then DONE pulses → every output is 0 after reset and DONE is ignored.
- With FIR_TIMEOUT_EN and TIMEOUT_CYC = 8, RUN with no DONE → err pulses 8 cycles after entering WAIT, no run_done, IDLE.
